// File: rtl/uu_acmac_tx_pkg.sv
// Shared definitions for the ACMAC transmit memory controller.
//   TX_MEM_DEPTH  : number of bytes in the attached frame memory
//   TX_FIFO_DEPTH : entries in the transmit output buffer
//   tx_state_t    : controller state encoding
//   addr_wrap_inc : next read address, wrapping at the end of memory
package uu_acmac_tx_pkg;

    localparam int TX_MEM_DEPTH  = 208;
    localparam int TX_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_t;

    function automatic logic [7:0] addr_wrap_inc(input logic [7:0] addr, input int depth);
        if (32'(addr) >= depth - 1)
            return 8'd0;
        return addr + 8'd1;
    endfunction

endpackage

// File: rtl/uu_acmac_tx_byte_fifo.sv
// Small show-ahead byte FIFO used as the transmit output buffer.
//   clk, rst_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   : write strobe and data (ignored when full unless popping)
//   pop, pop_data     : read strobe and head-of-queue data (pop ignored when empty)
//   full, empty, count: occupancy status
module uu_acmac_tx_byte_fifo
    import uu_acmac_tx_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = TX_FIFO_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    assign do_push = push & (~full | do_pop);
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (do_pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uu_acmac_tx_mem_ctrl.sv
// Transmit memory controller: shares one single-port frame memory between
// host byte writes and a frame fetch engine that streams tx_len bytes starting
// at tx_base out through a valid/ready byte interface.
//   clk, rst_n                : clock, asynchronous active-low reset
//   host_wr_*                 : host write request/ack/out-of-range error
//   tx_start/base/len         : frame start command; tx_busy/done/err status
//   tx_data/valid/ready/last  : outgoing byte stream
//   mem_*                     : memory port, read data valid the cycle after issue
module uu_acmac_tx_mem_ctrl
    import uu_acmac_tx_pkg::*;
#(
    parameter int MEM_DEPTH  = TX_MEM_DEPTH,
    parameter int FIFO_DEPTH = TX_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_wr_req,
    input  logic [7:0] host_wr_addr,
    input  logic [7:0] host_wr_data,
    output logic       host_wr_ack,
    output logic       host_wr_err,
    input  logic       tx_start,
    input  logic [7:0] tx_base,
    input  logic [7:0] tx_len,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       mem_en,
    output logic       mem_wen,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    tx_state_t        state_reg;
    logic [7:0]       rd_addr_reg;
    logic [7:0]       len_reg;
    logic [7:0]       issued_reg;
    logic [7:0]       popped_reg;
    logic             inflight_reg;
    logic             last_host_reg;
    logic [7:0]       addr_hold_reg;
    logic [7:0]       wdata_hold_reg;
    logic             tx_done_reg;
    logic             tx_err_reg;

    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             host_req;
    logic             host_bad;
    logic             fetch_elig;
    logic             host_gnt;
    logic             fetch_gnt;
    logic             start_ok;
    logic             pop;

    // Gating with rst_n keeps the memory port quiet while reset is held even
    // if a host request is pending.
    assign host_req   = host_wr_req & rst_n;
    assign host_bad   = (32'(host_wr_addr) >= MEM_DEPTH);
    // Eligibility uses registered occupancy only, so tx_ready never reaches mem_en.
    assign fetch_elig = (state_reg == ST_FETCH) && !fifo_full &&
                        ((32'(fifo_count) + 32'(inflight_reg)) < FIFO_DEPTH);
    // On contention the requester granted most recently yields.
    assign host_gnt   = host_req & (~fetch_elig | ~last_host_reg);
    assign fetch_gnt  = fetch_elig & ~host_gnt;

    assign mem_en     = fetch_gnt | (host_gnt & ~host_bad);
    assign mem_wen    = host_gnt & ~host_bad;
    assign mem_addr   = fetch_gnt ? rd_addr_reg : (mem_wen ? host_wr_addr : addr_hold_reg);
    assign mem_wdata  = mem_wen ? host_wr_data : wdata_hold_reg;
    assign host_wr_ack = host_gnt;
    assign host_wr_err = host_gnt & host_bad;

    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_empty ? 8'd0 : fifo_data;
    assign tx_last    = tx_valid && (popped_reg == len_reg - 8'd1);
    assign tx_busy    = (state_reg != ST_IDLE);
    assign tx_done    = tx_done_reg;
    assign tx_err     = tx_err_reg;
    assign pop        = tx_valid & tx_ready;

    assign start_ok   = (tx_len != 8'd0) && (32'(tx_len) <= MEM_DEPTH) &&
                        (32'(tx_base) < MEM_DEPTH);

    // Read data is pushed the cycle after issue; inflight_reg marks that cycle.
    uu_acmac_tx_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data (mem_rdata),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            rd_addr_reg    <= 8'd0;
            len_reg        <= 8'd0;
            issued_reg     <= 8'd0;
            popped_reg     <= 8'd0;
            inflight_reg   <= 1'b0;
            last_host_reg  <= 1'b1;   // fetch wins the first contended slot
            addr_hold_reg  <= 8'd0;
            wdata_hold_reg <= 8'd0;
            tx_done_reg    <= 1'b0;
            tx_err_reg     <= 1'b0;
        end else begin
            tx_done_reg  <= 1'b0;
            tx_err_reg   <= 1'b0;
            inflight_reg <= fetch_gnt;
            if (host_gnt || fetch_gnt)
                last_host_reg <= host_gnt;
            if (mem_en) begin
                addr_hold_reg  <= mem_addr;
                wdata_hold_reg <= mem_wdata;
            end
            if (pop)
                popped_reg <= popped_reg + 8'd1;

            case (state_reg)
                ST_IDLE: begin
                    if (tx_start) begin
                        if (start_ok) begin
                            rd_addr_reg <= tx_base;
                            len_reg     <= tx_len;
                            issued_reg  <= 8'd0;
                            popped_reg  <= 8'd0;
                            state_reg   <= ST_FETCH;
                        end else begin
                            tx_err_reg  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fetch_gnt) begin
                        rd_addr_reg <= addr_wrap_inc(rd_addr_reg, MEM_DEPTH);
                        issued_reg  <= issued_reg + 8'd1;
                        if (issued_reg == len_reg - 8'd1)
                            state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !inflight_reg) begin
                        state_reg   <= ST_IDLE;
                        tx_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uu_acmac_tx_mem_ctrl.md
UU_ACMAC_TX_MEM_CTRL -- requirements
Module: uu_acmac_tx_mem_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: host_wr_req  in  1; host_wr_addr  in  8; host_wr_data  in  8; host_wr_ack  out  1 (write accepted pulse); host_wr_err  out  1 (address >207 pulse).
REQ-004 SHALL provide: tx_start  in  1 (pulse); tx_base  in  8 (first byte address); tx_len  in  8 (byte count); tx_busy  out  1; tx_done  out  1 (pulse); tx_err  out  1 (pulse).
REQ-005 SHALL provide: tx_data  out  8; tx_valid  out  1; tx_ready  in  1; tx_last  out  1 (final byte).
REQ-006 SHALL provide memory port: mem_en  out  1; mem_wen  out  1 (1=write); mem_addr  out  8; mem_wdata  out  8; mem_rdata  in  8, valid cycle after read issue.
REQ-007 SHALL use parameters: MEM_DEPTH default 208, memory bytes; FIFO_DEPTH default 2, output buffer entries.

Function
REQ-008 SHALL implement states IDLE, FETCH, DRAIN; tx_busy=1 in FETCH and DRAIN.
REQ-009 IDLE + tx_start with 1<=tx_len<=MEM_DEPTH and tx_base<MEM_DEPTH SHALL latch base/len, go FETCH next cycle.
REQ-010 IDLE + tx_start with tx_len=0, tx_len>MEM_DEPTH or tx_base>=MEM_DEPTH SHALL pulse tx_err one cycle, stay IDLE.
REQ-011 tx_start while tx_busy SHALL be ignored, no error.
REQ-012 FETCH SHALL issue read (mem_en=1, mem_wen=0) only when FIFO occupancy + in-flight reads < FIFO_DEPTH and port granted.
REQ-013 Read address SHALL increment per issued read, wrapping MEM_DEPTH-1 -> 0.
REQ-014 mem_rdata SHALL be pushed into FIFO exactly one cycle after its read issue.
REQ-015 After tx_len reads issued, SHALL go DRAIN; DRAIN -> IDLE when FIFO empty and no read in flight, with tx_done pulsed that cycle.
REQ-016 tx_valid SHALL equal FIFO non-empty; byte popped when tx_valid & tx_ready; tx_data, tx_valid, tx_last stable while tx_valid & !tx_ready.
REQ-017 tx_last SHALL be 1 with tx_valid on byte number tx_len only.
REQ-018 Host write SHALL be issued as mem_en=1, mem_wen=1, mem_addr=host_wr_addr, mem_wdata=host_wr_data; host_wr_ack pulses the same cycle.
REQ-019 host_wr_req SHALL be held by requester until host_wr_ack; arbiter SHALL grant at most one access per cycle.
REQ-020 Arbitration: host write wins when fetch not eligible; when both eligible, grant alternates, last-granted loses, so neither starves (worst-case wait 1 cycle).
REQ-021 host_wr_addr>=MEM_DEPTH SHALL not drive mem_en, SHALL pulse host_wr_ack and host_wr_err together, consuming one grant slot.
REQ-022 No access granted: mem_en=0, mem_wen=0, mem_addr/mem_wdata hold last value.
REQ-023 Host writes to addresses currently being fetched SHALL not be blocked; ordering is grant order.

Reset
REQ-024 rst_n low SHALL force IDLE, FIFO empty, in-flight cleared, arbiter priority to fetch, all outputs 0, regardless of clock.
REQ-025 Reset mid-frame SHALL abort frame, no tx_done; read data returning after reset release SHALL be discarded.

Structure
REQ-026 MEM_DEPTH, FIFO_DEPTH and state encoding SHALL live in shared package uu_acmac_tx_pkg.
REQ-027 Output buffer SHALL be sub-module uu_acmac_tx_byte_fifo (8-bit, FIFO_DEPTH entries, push/pop/full/empty/count).
REQ-028 Total RTL 120-400 lines; no combinational path from tx_ready to mem_en beyond one gate level.

Verification
REQ-029 Host writes 0xA0..0xA9 to 0..9, then tx_start base=0 len=10, tx_ready=1 -> tx_data 0xA0..0xA9 in order, tx_last on 0xA9, tx_done once, 10 mem reads.
REQ-030 tx_start base=205 len=5 -> reads addresses 205,206,207,0,1; tx_last on 5th byte.
REQ-031 tx_ready toggled 1/0 every cycle, len=8 -> no byte lost/duplicated, outputs stable while stalled, occupancy never >2.
REQ-032 host_wr_req held continuously during 16-byte fetch -> grants alternate host/fetch, both complete, no starvation >1 cycle.
REQ-033 tx_start len=0, len=209, base=208 -> tx_err pulse each, tx_busy stays 0; host_wr_addr=208 -> ack+err, no mem_en.
REQ-034 rst_n low during byte 4 of 10 -> outputs 0 immediately; after release, new 3-byte frame transfers correctly, no stale byte.
